// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable inter-stage pipeline register with valid/ready
// handshake, flush, bubble control zeroing and a saturating stall counter.
//
// Build option:
//   PIPE_SKID_EN defined   -> two-entry (main + skid) buffer; in_ready is a
//                             registered signal (!s_valid), so there is no
//                             combinational out_ready -> in_ready path.
//   PIPE_SKID_EN undefined -> single main entry; in_ready = !m_valid || out_ready.
//
// The main entry always drives the outputs. Control is masked to zero while
// the stage is empty so a bubble can never trigger a write downstream. Data is
// left untouched on flush/drain to avoid needless toggling of wide buses.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy states. ST_SKID is only reachable when the skid entry exists.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e              state_q, state_d;

  // Main entry: the one presented on the outputs.
  logic                m_valid_q, m_valid_d;
  logic [CTRL_W-1:0]   m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0]   m_data_q,  m_data_d;

`ifdef PIPE_SKID_EN
  // Skid entry: catches the one extra beat accepted while downstream stalls.
  logic                s_valid_q, s_valid_d;
  logic [CTRL_W-1:0]   s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0]   s_data_q,  s_data_d;
`endif

  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Output and handshake wiring (all sourced from flops, except the
  // single-entry in_ready which must look at out_ready to sustain 1/cycle).
  // ---------------------------------------------------------------------------
  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : {CTRL_W{1'b0}};
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_SKID_EN
  assign in_ready  = ~s_valid_q;
`else
  assign in_ready  = ~m_valid_q | out_ready;
`endif

  // Next-state, entry-load and flush logic of the occupancy state machine.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
`ifdef PIPE_SKID_EN
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
`endif

    if (flush) begin
      // Kill everything held and drop any same-cycle input; data is kept.
      state_d   = ST_EMPTY;
      m_valid_d = 1'b0;
`ifdef PIPE_SKID_EN
      s_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          // in_ready is 1 here in both builds.
          if (in_valid) begin
            state_d   = ST_FULL;
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
          end else begin
            state_d   = ST_EMPTY;
          end
        end

        ST_FULL: begin
          if (out_ready && in_valid) begin
            // Concurrent consume and accept: replace main, no bubble.
            state_d   = ST_FULL;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
          end else if (out_ready) begin
            state_d   = ST_EMPTY;
            m_valid_d = 1'b0;
`ifdef PIPE_SKID_EN
          end else if (in_valid) begin
            // Downstream stalled but we still advertised ready: park in skid.
            state_d   = ST_SKID;
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
`endif
          end else begin
            state_d   = ST_FULL;
          end
        end

`ifdef PIPE_SKID_EN
        ST_SKID: begin
          // in_ready is 0, so only the skid-to-main move can happen.
          if (out_ready) begin
            state_d   = ST_FULL;
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
          end else begin
            state_d   = ST_SKID;
          end
        end
`endif

        default: begin
          // Illegal encoding: recover to a clean empty stage.
          state_d   = ST_EMPTY;
          m_valid_d = 1'b0;
`ifdef PIPE_SKID_EN
          s_valid_d = 1'b0;
`endif
        end
      endcase
    end
  end

  // Saturating count of cycles in which a valid entry is held back.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      m_valid_q   <= 1'b0;
      m_ctrl_q    <= {CTRL_W{1'b0}};
      m_data_q    <= {DATA_W{1'b0}};
`ifdef PIPE_SKID_EN
      s_valid_q   <= 1'b0;
      s_ctrl_q    <= {CTRL_W{1'b0}};
      s_data_q    <= {DATA_W{1'b0}};
`endif
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
`ifdef PIPE_SKID_EN
      s_valid_q   <= s_valid_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
`endif
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. The reference model is a bounded
// FIFO (capacity 2 with the skid buffer, 1 without) plus a saturating counter.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 11;
  localparam int NW = 16;

`ifdef PIPE_SKID_EN
  localparam bit   SKID       = 1'b1;
  localparam int   ACC_BP     = 2;
  localparam logic RDY4_EXP   = 1'b1;
`else
  localparam bit   SKID       = 1'b0;
  localparam int   ACC_BP     = 1;
  localparam logic RDY4_EXP   = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  // Narrow-counter instance for saturation.
  logic          in_valid4;
  logic          in_ready4;
  logic [CW-1:0] in_ctrl4;
  logic [DW-1:0] in_data4;
  logic          out_valid4;
  logic          out_ready4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_ctrl(in_ctrl4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_ctrl(out_ctrl4), .out_data(out_data4),
    .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [CW+DW-1:0] mq[$];
  logic [DW-1:0]    m_last;
  int unsigned      m_stall;
  logic [DW-1:0]    dut_log[$];

  logic          pre_rdy_exp, pre_rdy_obs, acc_obs;
  logic          exp_valid;
  logic [CW-1:0] exp_ctrl;
  logic [DW-1:0] exp_data;
  logic [NW-1:0] exp_stall;

  int n_cmp;
  int n_fail;

  // One clock: settle inputs, note handshake, advance model across the edge.
  task automatic step();
    logic rdy;
    logic pop;
    #1;
    rdy = SKID ? (mq.size() < 2) : ((mq.size() == 0) || out_ready);
    pre_rdy_exp = rdy;
    pre_rdy_obs = in_ready;
    acc_obs     = in_valid && in_ready;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_last  = '0;
      m_stall = 0;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (pop) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (in_valid && rdy) mq.push_back({in_ctrl, in_data});
      if (mq.size() > 0) m_last = mq[0][DW-1:0];
    end
    exp_valid = (mq.size() > 0);
    exp_ctrl  = exp_valid ? mq[0][CW+DW-1:DW] : '0;
    exp_data  = m_last;
    exp_stall = NW'(m_stall);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 11'h7FF;
    in_data = $urandom; out_ready = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 11'h000) begin n_fail++; $display("FAIL reset_ctrl: got %h want 000", out_ctrl); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = DW'(k); in_ctrl = CW'($urandom);
      step();
      n_cmp++; if (pre_rdy_obs !== 1'b1) begin n_fail++; $display("FAIL stream_ready: beat %0d got %b want 1", k, pre_rdy_obs); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: beat %0d got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== DW'(k)) begin n_fail++; $display("FAIL stream_data: got %0d want %0d", out_data, k); end
      n_cmp++; if (out_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL stream_ctrl: got %h want %h", out_ctrl, exp_ctrl); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [3];
    int idx;
    int unsigned stall0;
    drain();
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    idx = 0;
    stall0 = m_stall;
    dut_log.delete();
    for (int c = 0; c < 13; c++) begin
      out_ready = (c >= 5);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? vals[idx] : '0;
      in_ctrl   = CW'($urandom);
      if (out_valid === 1'b1 && out_ready) dut_log.push_back(out_data);
      step();
      if (acc_obs) idx++;
      n_cmp++; if (pre_rdy_obs !== pre_rdy_exp) begin n_fail++; $display("FAIL bp_in_ready: cyc %0d got %b want %b", c, pre_rdy_obs, pre_rdy_exp); end
      n_cmp++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL bp_valid: cyc %0d got %b want %b", c, out_valid, exp_valid); end
      n_cmp++; if (out_data !== exp_data) begin n_fail++; $display("FAIL bp_data: cyc %0d got %h want %h", c, out_data, exp_data); end
      if (c == 4) begin
        n_cmp++; if (idx !== ACC_BP) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", idx, ACC_BP); end
        n_cmp++; if (stall_cnt !== NW'(stall0 + 4)) begin n_fail++; $display("FAIL bp_stall: got %0d want %0d", stall_cnt, stall0 + 4); end
      end
    end
    n_cmp++; if (dut_log.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", dut_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < dut_log.size()) begin
        n_cmp++; if (dut_log[i] !== vals[i]) begin n_fail++; $display("FAIL bp_order: pos %0d got %h want %h", i, dut_log[i], vals[i]); end
      end
    end
    n_cmp++; if (stall_cnt !== NW'(stall0 + 4)) begin n_fail++; $display("FAIL bp_stall_final: got %0d want %0d", stall_cnt, stall0 + 4); end
  endtask

  task automatic test_flush();
    drain();
    dut_log.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 11'h123; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    flush = 1'b1; in_data = 32'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 11'h000) begin n_fail++; $display("FAIL flush_ctrl: got %h want 000", out_ctrl); end
    n_cmp++; if (out_data !== exp_data) begin n_fail++; $display("FAIL flush_data_kept: got %h want %h", out_data, exp_data); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid === 1'b1 && out_ready) dut_log.push_back(out_data);
      step();
    end
    n_cmp++; if (dut_log.size() !== 0) begin n_fail++; $display("FAIL flush_leak: %0d entries emitted after flush, want 0", dut_log.size()); end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] d;
    drain();
    d = $urandom;
    in_valid = 1'b1; in_ctrl = 11'h5A5; in_data = d;
    step();
    n_cmp++; if (out_ctrl !== 11'h5A5) begin n_fail++; $display("FAIL bubble_ctrl_live: got %h want 5a5", out_ctrl); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_ctrl !== 11'h000) begin n_fail++; $display("FAIL bubble_ctrl_zero: got %h want 000", out_ctrl); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== d) begin n_fail++; $display("FAIL bubble_data_kept: got %h want %h", out_data, d); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b1; in_ctrl4 = 11'h0F0; in_data4 = 32'hCAFE; out_ready4 = 1'b0;
    step();
    in_valid4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_cmp++; if (stall_cnt4 !== 4'((k > 15) ? 15 : k)) begin n_fail++; $display("FAIL sat_cnt: cyc %0d got %0d want %0d", k, stall_cnt4, (k > 15) ? 15 : k); end
    end
    n_cmp++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b want 1", out_valid4); end
    n_cmp++; if (out_data4 !== 32'hCAFE) begin n_fail++; $display("FAIL sat_data: got %h want cafe", out_data4); end
    n_cmp++; if (out_ctrl4 !== 11'h0F0) begin n_fail++; $display("FAIL sat_ctrl: got %h want 0f0", out_ctrl4); end
    n_cmp++; if (in_ready4 !== RDY4_EXP) begin n_fail++; $display("FAIL sat_in_ready: got %b want %b", in_ready4, RDY4_EXP); end
    out_ready4 = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      in_ctrl   = CW'($urandom);
      in_data   = $urandom;
      step();
      if (rst) begin
        n_cmp++; if (pre_rdy_obs !== pre_rdy_exp) begin n_fail++; $display("FAIL rand_in_ready: cyc %0d got %b want %b", c, pre_rdy_obs, pre_rdy_exp); end
      end
      n_cmp++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid: cyc %0d got %b want %b", c, out_valid, exp_valid); end
      n_cmp++; if (out_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rand_ctrl: cyc %0d got %h want %h", c, out_ctrl, exp_ctrl); end
      n_cmp++; if (out_data !== exp_data) begin n_fail++; $display("FAIL rand_data: cyc %0d got %h want %h", c, out_data, exp_data); end
      n_cmp++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL rand_stall: cyc %0d got %0d want %0d", c, stall_cnt, exp_stall); end
    end
    rst = 1'b1; flush = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_last = '0; m_stall = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_ctrl4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
